jtframe_dump_win: RTL and testbench
===================================

# jtframe_dump_win

Frame-windowed simulation/debug trigger controller for the jtframe test harness. Counts video frames on falling edges of vertical sync, optionally arms only once ROM download finishes, and drives CH independent dump-enable windows, each with its own start frame, length and mode. Sits beside the game core in the test top and feeds waveform-dump or logic-analyser capture enables. Multi-channel, synthesizable generalisation of the single start-frame dump trigger.

## Interface
- CH, 4, number of dump channels (1..16)
- FW, 32, frame counter width
- LW, 16, window length counter width
- LOAD_ARM, 1, 1: arm on falling edge of `led` (download end); 0: armed out of reset
- CH0_START, 0, reset value of channel 0 start frame
- CH0_MODE, 2'd0, reset value of channel 0 mode
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- vs  in  1  vertical sync, synchronous to clk
- led  in  1  download-active flag, synchronous to clk
- cfg_we  in  1  config write strobe
- cfg_ch  in  max(1,$clog2(CH))  channel selected for write
- cfg_start  in  FW  start frame
- cfg_len  in  LW  window length in frames
- cfg_mode  in  2  0 OFF, 1 ONESHOT, 2 FOREVER, 3 reserved (treated as OFF)
- frame_cnt  out  FW  frames since arm
- armed  out  1  controller armed
- ch_en  out  CH  per-channel window active
- ch_done  out  CH  per-channel ONESHOT window finished
- dump_on  out  1  OR of ch_en
- dump_trig  out  1  one-cycle pulse when dump_on rises

## Operation
- Edge detect: vs_l, led_l registered; vs_fall = vs_l & ~vs; led_fall = led_l & ~led; led_rise = ~led_l & led.
- Arm event: led_fall while not armed (LOAD_ARM=1). Sets armed, frame_cnt<=0. Takes priority over a coincident vs_fall (vs_fall ignored that cycle).
- Disarm: led_rise while armed (new download). armed<=0, frame_cnt held; every channel in ACTIVE/DONE returns to WAIT (window length reloaded at next activation). With LOAD_ARM=0, led is ignored.
- frame_cnt: +1 on each vs_fall while armed; saturates at all-ones.
- Channel states: IDLE, WAIT, ACTIVE, DONE.
  - IDLE: mode OFF/reserved. ch_en=0, ch_done=0.
  - WAIT: on an evaluation event (vs_fall or arm event, armed) with next frame_cnt >= start -> ACTIVE, remaining<=len. For arm event next frame_cnt=0, so start=0 activates on arm. ONESHOT with len=0 -> DONE directly, ch_en never asserted.
  - ACTIVE: ONESHOT: each later vs_fall decrements remaining; reaching 0 -> DONE. FOREVER: stays until reconfigured/disarmed.
  - DONE: ch_done=1 until reconfig, disarm or reset.
- cfg_we: loads start/len/mode of cfg_ch; state <= WAIT (ONESHOT/FOREVER) or IDLE (OFF). Wins over any same-cycle event for that channel; other channels unaffected. cfg_ch >= CH ignored. Start already passed -> activates at next vs_fall.
- dump_on = |ch_en; dump_trig = dump_on & ~dump_on_l.

## Timing
- Reset: frame_cnt=0, armed=~LOAD_ARM, ch_en=0, ch_done=0, dump_on=0, dump_trig=0; channel 0 start=CH0_START, mode=CH0_MODE, state WAIT if mode 1/2 else IDLE; other channels start=0, len=0, IDLE.
- vs_fall/led_fall decided in the cycle vs/led is first sampled low; frame_cnt, armed, ch_en, ch_done update at the next clk edge (1-cycle latency).
- ONESHOT len=N: ch_en high for exactly N vs falling edges worth of frames (activation edge to Nth following edge).
- dump_on same cycle as ch_en (combinational from registers); dump_trig one cycle later, width 1 clk.
- rst_n low mid-window: all outputs to reset values immediately (asynchronous).

## Test plan
- LOAD_ARM=1, CH0 ONESHOT start=3 len=2: led 1->0, five vs pulses -> armed 1 cycle after led fall; ch_en[0] rises after 3rd vs_fall, falls after 5th; ch_done[0]=1; dump_trig one pulse.
- CH1 FOREVER start=0: arm -> ch_en[1]=1 cycle after arm, stays through 100 frames; led rise -> armed=0, ch_en[1]=0, frame_cnt held; led fall -> re-arm, frame_cnt=0, ch_en[1]=1.
- ONESHOT len=0 start=2 -> ch_done after 2nd vs_fall, ch_en never high, dump_trig never.
- cfg_we on ch2 in the same cycle as the vs_fall completing its window -> ch2 back to WAIT, ch_done[2]=0; ch0 counting unaffected.
- FW=4: 20 vs pulses -> frame_cnt saturates at 15; start=15 channel activates, start later written 9 activates at next vs_fall.
- rst_n pulsed low while two channels active -> all outputs 0 asynchronously; CH0_START/CH0_MODE restored.

Source files
------------

// File: rtl/jtframe_dump_win.sv
// jtframe_dump_win: frame-windowed dump enables, CH channels each with start frame, length and mode,
// counting vs falling edges once armed (optionally at end of ROM download).
module jtframe_dump_win #(
  parameter int CH = 4,
  parameter int FW = 32,
  parameter int LW = 16,
  parameter bit LOAD_ARM = 1'b1,
  parameter logic [FW-1:0] CH0_START = '0,
  parameter logic [1:0] CH0_MODE = 2'd0,
  localparam int CW = CH > 1 ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vs,
  input  logic          led,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [FW-1:0] cfg_start,
  input  logic [LW-1:0] cfg_len,
  input  logic [1:0]    cfg_mode,
  output logic [FW-1:0] frame_cnt,
  output logic          armed,
  output logic [CH-1:0] ch_en,
  output logic [CH-1:0] ch_done,
  output logic          dump_on,
  output logic          dump_trig
);
  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DONE} st_t;
  localparam st_t ST0 = (CH0_MODE == 2'd1 || CH0_MODE == 2'd2) ? WAIT : IDLE;
  logic r_vs_l, r_led_l, r_armed, r_dump_l, r_trig;
  logic [FW-1:0] r_frame_cnt, w_fc_nxt;
  logic [FW-1:0] r_start [CH];
  logic [LW-1:0] r_len [CH];
  logic [LW-1:0] r_rem [CH];
  logic [LW-1:0] w_rem_nxt [CH];
  logic [1:0]    r_mode [CH];
  st_t           r_st [CH];
  st_t           w_st_nxt [CH];
  logic w_vs_fall, w_arm, w_disarm, w_tick, w_eval;
  assign w_vs_fall = r_vs_l & ~vs;
  assign w_arm     = LOAD_ARM & r_led_l & ~led & ~r_armed;
  assign w_disarm  = LOAD_ARM & ~r_led_l & led & r_armed;
  assign w_tick    = w_vs_fall & r_armed & ~w_disarm;
  assign w_eval    = w_arm | w_tick;
  // arm restarts the count at 0 so a start of 0 activates on the arm event itself
  assign w_fc_nxt  = w_arm ? '0 : (w_tick && !(&r_frame_cnt)) ? r_frame_cnt + FW'(1) : r_frame_cnt;
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      w_st_nxt[i]  = r_st[i];
      w_rem_nxt[i] = r_rem[i];
      if (cfg_we && cfg_ch == CW'(i)) begin
        w_st_nxt[i] = (cfg_mode == 2'd1 || cfg_mode == 2'd2) ? WAIT : IDLE;
      end else if (w_disarm) begin
        w_st_nxt[i] = (r_st[i] == ACTIVE || r_st[i] == DONE) ? WAIT : r_st[i];
      end else if (r_st[i] == WAIT && w_eval && w_fc_nxt >= r_start[i]) begin
        w_st_nxt[i]  = (r_mode[i] == 2'd1 && r_len[i] == '0) ? DONE : ACTIVE;
        w_rem_nxt[i] = r_len[i];
      end else if (r_st[i] == ACTIVE && r_mode[i] == 2'd1 && w_tick) begin
        w_rem_nxt[i] = r_rem[i] - LW'(1);
        w_st_nxt[i]  = r_rem[i] <= LW'(1) ? DONE : ACTIVE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_l      <= 1'b0;
      r_led_l     <= 1'b0;
      r_armed     <= !LOAD_ARM;
      r_frame_cnt <= '0;
      r_dump_l    <= 1'b0;
      r_trig      <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        r_st[i]    <= i == 0 ? ST0 : IDLE;
        r_rem[i]   <= '0;
        r_start[i] <= i == 0 ? CH0_START : '0;
        r_len[i]   <= '0;
        r_mode[i]  <= i == 0 ? CH0_MODE : 2'd0;
      end
    end else begin
      r_vs_l      <= vs;
      r_led_l     <= led;
      r_armed     <= w_arm ? 1'b1 : w_disarm ? 1'b0 : r_armed;
      r_frame_cnt <= w_fc_nxt;
      r_dump_l    <= dump_on;
      r_trig      <= dump_on & ~r_dump_l;
      for (int i = 0; i < CH; i++) begin
        r_st[i]  <= w_st_nxt[i];
        r_rem[i] <= w_rem_nxt[i];
        if (cfg_we && cfg_ch == CW'(i)) begin
          r_start[i] <= cfg_start;
          r_len[i]   <= cfg_len;
          r_mode[i]  <= cfg_mode;
        end
      end
    end
  end
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      ch_en[i]   = r_st[i] == ACTIVE;
      ch_done[i] = r_st[i] == DONE;
    end
  end
  assign dump_on   = |ch_en;
  assign dump_trig = r_trig;
  assign frame_cnt = r_frame_cnt;
  assign armed     = r_armed;
endmodule

// File: tb/tb_jtframe_dump_win.sv
// tb_jtframe_dump_win: scoreboard bench; u1 is the default download-armed build,
// u2 a 4-bit frame counter build armed from reset with channel 0 FOREVER at frame 15.
module tb_jtframe_dump_win;
  logic clk = 0, rst_n = 0, vs = 0, led = 1, cfg_we = 0;
  logic [1:0] cfg_ch = 0, cfg_mode = 0;
  logic [31:0] cfg_start = 0;
  logic [15:0] cfg_len = 0;
  logic c2_we = 0;
  logic [1:0] c2_ch = 0, c2_mode = 0;
  logic [3:0] c2_start = 0;
  logic [15:0] c2_len = 0;
  logic [31:0] frame_cnt;
  logic armed, dump_on, dump_trig;
  logic [3:0] ch_en, ch_done;
  logic [3:0] f2, e2, d2;
  logic a2, o2, t2;
  jtframe_dump_win u1 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .led(led), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_mode(cfg_mode), .frame_cnt(frame_cnt),
    .armed(armed), .ch_en(ch_en), .ch_done(ch_done), .dump_on(dump_on), .dump_trig(dump_trig)
  );
  jtframe_dump_win #(.CH(4), .FW(4), .LW(16), .LOAD_ARM(1'b0), .CH0_START(4'd15), .CH0_MODE(2'd2)) u2 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .led(1'b0), .cfg_we(c2_we), .cfg_ch(c2_ch),
    .cfg_start(c2_start), .cfg_len(c2_len), .cfg_mode(c2_mode), .frame_cnt(f2),
    .armed(a2), .ch_en(e2), .ch_done(d2), .dump_on(o2), .dump_trig(t2)
  );
  always #5 clk = ~clk;
  typedef struct {string tag; int sel; logic [31:0] exp;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  function automatic logic [31:0] obs(int sel);
    case (sel)
      0: return frame_cnt;
      1: return 32'(armed);
      2: return 32'(ch_en);
      3: return 32'(ch_done);
      4: return 32'(dump_on);
      5: return 32'(dump_trig);
      6: return 32'(f2);
      7: return 32'(e2);
      8: return 32'(a2);
      default: return '0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    q.push_back('{tag, sel, exp});
  endtask
  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask
  task automatic rise();
    vs = 1;
    tick();
    vs = 0;
  endtask
  task automatic pulse();
    rise();
    tick();
  endtask
  task automatic cfg(input logic [1:0] ch, input logic [31:0] st, input logic [15:0] ln, input logic [1:0] md);
    cfg_ch = ch; cfg_start = st; cfg_len = ln; cfg_mode = md; cfg_we = 1;
    tick();
    cfg_we = 0;
  endtask
  initial begin
    push("rst armed", 1, 0); push("rst cnt", 0, 0); push("rst en", 2, 0); push("rst done", 3, 0);
    push("rst on", 4, 0); push("rst trig", 5, 0); push("rst u2 armed", 8, 1); push("rst u2 en", 7, 0);
    tick();
    tick();
    rst_n = 1;
    cfg(0, 3, 2, 1);
    cfg(1, 0, 0, 2);
    cfg(3, 2, 0, 1);
    push("unarmed en", 2, 0); push("unarmed", 1, 0);
    tick();
    led = 0;
    push("arm", 1, 1); push("arm cnt", 0, 0); push("arm en", 2, 4'b0010); push("arm on", 4, 1); push("arm trig0", 5, 0);
    tick();
    push("trig", 5, 1);
    tick();
    push("trig width", 5, 0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      rise();
      push("t1 cnt", 0, k);
      push("t1 en", 2, {3'b001, 1'(k >= 3 && k < 5)});
      push("t1 done", 3, {1'(k >= 2), 2'b00, 1'(k >= 5)});
      push("t1 trig", 5, 0);
      tick();
    end
    cfg(2, 0, 1, 1);
    rise();
    push("ch2 act", 2, 4'b0110); push("ch2 done", 3, 4'b1001);
    tick();
    rise();
    cfg_we = 1; cfg_ch = 2; cfg_start = 1000; cfg_len = 1; cfg_mode = 1;
    push("cfg win en", 2, 4'b0010); push("cfg win done", 3, 4'b1001); push("cfg win cnt", 0, 7);
    tick();
    cfg_we = 0;
    repeat (93) pulse();
    push("fv cnt", 0, 100); push("fv en", 2, 4'b0010); push("fv on", 4, 1);
    tick();
    led = 1;
    push("disarm", 1, 0); push("dis cnt", 0, 100); push("dis en", 2, 0); push("dis done", 3, 0); push("dis on", 4, 0);
    tick();
    rise();
    push("held cnt", 0, 100); push("held en", 2, 0);
    tick();
    led = 0;
    push("rearm", 1, 1); push("rearm cnt", 0, 0); push("rearm en", 2, 4'b0010);
    tick();
    push("rearm trig", 5, 1);
    tick();
    pulse();
    rise();
    push("len0 done", 3, 4'b1000); push("len0 en", 2, 4'b0010); push("len0 trig", 5, 0);
    tick();
    rise();
    push("two act", 2, 4'b0011);
    tick();
    #2 rst_n = 0;
    #1;
    push("ar cnt", 0, 0); push("ar armed", 1, 0); push("ar en", 2, 0); push("ar done", 3, 0);
    push("ar on", 4, 0); push("ar trig", 5, 0); push("ar u2 armed", 8, 1); push("ar u2 en", 7, 0); push("ar u2 cnt", 6, 0);
    drain();
    @(posedge clk);
    #1 rst_n = 1;
    for (int k = 1; k <= 20; k++) begin
      rise();
      push("sat cnt", 6, k > 15 ? 15 : k);
      push("sat en", 7, 32'(k >= 15));
      tick();
    end
    c2_we = 1; c2_ch = 1; c2_start = 9; c2_len = 0; c2_mode = 2;
    push("late wr", 7, 4'b0001);
    tick();
    c2_we = 0;
    rise();
    push("late act", 7, 4'b0011); push("late cnt", 6, 15);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
